// File: rtl/uart2wb_pkg.sv
// Shared constants and state type for the UART-to-Wishbone command engine.
package uart2wb_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] RSP_WACK  = 8'hA5;
  localparam logic [7:0] RSP_ERR   = 8'hEE;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    WB    = 3'd3,
    RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/uart2wb_cmd.sv
// Packet parser, single-transfer Wishbone master and response streamer.
// Optional ack-wait timeout enabled by defining UART2WB_TIMEOUT_EN.
module uart2wb_cmd
  import uart2wb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic [7:0]          tx_data,
  output logic                wb_cyc,
  output logic                wb_stb,
  output logic                wb_we,
  output logic [ADDR_W-1:0]   wb_adr,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic [DATA_W/8-1:0] wb_sel,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_ack,
  output logic                overrun
);

  localparam int NA    = ADDR_W / 8;
  localparam int ND    = DATA_W / 8;
  localparam int MAXB  = (NA > ND) ? NA : ND;
  localparam int CNT_W = $clog2(MAXB + 1);

  state_e              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic                we_r, we_s;
  logic [ADDR_W-1:0]   adr_r, adr_s;
  logic [DATA_W-1:0]   wdat_r, wdat_s;
  logic [DATA_W-1:0]   rsp_r, rsp_s;
  logic                cyc_r, cyc_s;
  logic                tx_valid_r, tx_valid_s;
  logic                overrun_r, overrun_s;
  logic                to_expired_s;

`ifdef UART2WB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_r;

  // Ack-wait counter: zero outside WB, so it restarts on every entry to WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if (state_r != WB) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else begin
      to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
    end
  end

  assign to_expired_s = (to_cnt_r == TO_W'(TIMEOUT - 1));
`else
  localparam int timeout_unused = TIMEOUT;
  assign to_expired_s = 1'b0;
`endif

  // Next-state and next-register values for the whole engine.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    we_s       = we_r;
    adr_s      = adr_r;
    wdat_s     = wdat_r;
    rsp_s      = rsp_r;
    cyc_s      = cyc_r;
    tx_valid_s = tx_valid_r;
    overrun_s  = overrun_r | (rx_valid & ((state_r == WB) | (state_r == RESP)));

    case (state_r)
      IDLE: begin
        if (rx_valid && ((rx_data == CMD_WRITE) || (rx_data == CMD_READ))) begin
          we_s    = (rx_data == CMD_WRITE);
          cnt_s   = {CNT_W{1'b0}};
          state_s = ADDR;
        end else begin
          state_s = IDLE;
        end
      end

      ADDR: begin
        if (rx_valid) begin
          adr_s = (adr_r << 8) | ADDR_W'(rx_data);
          if (cnt_r == CNT_W'(NA - 1)) begin
            cnt_s = {CNT_W{1'b0}};
            if (we_r) begin
              state_s = WDATA;
            end else begin
              state_s = WB;
              cyc_s   = 1'b1;
            end
          end else begin
            cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_s = ADDR;
        end
      end

      WDATA: begin
        if (rx_valid) begin
          wdat_s = (wdat_r << 8) | DATA_W'(rx_data);
          if (cnt_r == CNT_W'(ND - 1)) begin
            cnt_s   = {CNT_W{1'b0}};
            state_s = WB;
            cyc_s   = 1'b1;
          end else begin
            cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_s = WDATA;
        end
      end

      // cnt holds the number of response bytes still to follow the current one.
      WB: begin
        if (wb_ack) begin
          cyc_s      = 1'b0;
          tx_valid_s = 1'b1;
          state_s    = RESP;
          if (we_r) begin
            rsp_s = DATA_W'(RSP_WACK) << (DATA_W - 8);
            cnt_s = {CNT_W{1'b0}};
          end else begin
            rsp_s = wb_dat_i;
            cnt_s = CNT_W'(ND - 1);
          end
        end else if (to_expired_s) begin
          cyc_s      = 1'b0;
          tx_valid_s = 1'b1;
          state_s    = RESP;
          rsp_s      = DATA_W'(RSP_ERR) << (DATA_W - 8);
          cnt_s      = {CNT_W{1'b0}};
        end else begin
          state_s = WB;
        end
      end

      RESP: begin
        if (tx_ready) begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            tx_valid_s = 1'b0;
            state_s    = IDLE;
          end else begin
            cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            rsp_s = rsp_r << 8;
          end
        end else begin
          state_s = RESP;
        end
      end

      default: begin
        state_s    = IDLE;
        cyc_s      = 1'b0;
        tx_valid_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      we_r       <= 1'b0;
      adr_r      <= {ADDR_W{1'b0}};
      wdat_r     <= {DATA_W{1'b0}};
      rsp_r      <= {DATA_W{1'b0}};
      cyc_r      <= 1'b0;
      tx_valid_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      we_r       <= we_s;
      adr_r      <= adr_s;
      wdat_r     <= wdat_s;
      rsp_r      <= rsp_s;
      cyc_r      <= cyc_s;
      tx_valid_r <= tx_valid_s;
      overrun_r  <= overrun_s;
    end
  end

  assign wb_cyc   = cyc_r;
  assign wb_stb   = cyc_r;
  assign wb_we    = we_r;
  assign wb_adr   = adr_r;
  assign wb_dat_o = wdat_r;
  assign wb_sel   = {(DATA_W/8){1'b1}};
  assign tx_valid = tx_valid_r;
  assign tx_data  = rsp_r[DATA_W-1 -: 8];
  assign overrun  = overrun_r;

endmodule

// File: tb/tb_uart2wb_cmd.sv
// Scoreboard bench for uart2wb_cmd: packet-level reference model, RAM slave, tx/wb monitors.
module tb_uart2wb_cmd;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int ND     = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              tx_valid;
  logic              tx_ready = 1'b1;
  logic [7:0]        tx_data;
  logic              wb_cyc, wb_stb, wb_we;
  logic [ADDR_W-1:0] wb_adr;
  logic [DATA_W-1:0] wb_dat_o;
  logic [3:0]        wb_sel;
  logic [DATA_W-1:0] wb_dat_i = '0;
  logic              wb_ack = 1'b0;
  logic              overrun;

  always #5 clk = ~clk;

  uart2wb_cmd #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_o(wb_dat_o), .wb_sel(wb_sel), .wb_dat_i(wb_dat_i),
    .wb_ack(wb_ack), .overrun(overrun)
  );

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat;
  } wb_exp_t;

  wb_exp_t           wb_q[$];
  logic [7:0]        tx_q[$];
  logic [DATA_W-1:0] ref_mem[logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] ram[logic [ADDR_W-1:0]];

  int   checks = 0;
  int   errors = 0;
  logic exp_ovr = 1'b0;
  bit   rand_ready = 1'b0;
  bit   no_ack = 1'b0;
  int   fixed_delay = -1;

  function automatic logic [DATA_W-1:0] init_val(logic [ADDR_W-1:0] a);
    return {a, ~a};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one byte for exactly one edge; called in the post-edge phase.
  task automatic send_byte(logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_gap(logic [7:0] b, bit gaps);
    send_byte(b);
    if (gaps) repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic do_write(logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d, bit gaps);
    wb_exp_t e;
    e.we = 1'b1; e.adr = a; e.dat = d;
    ref_mem[a] = d;
    wb_q.push_back(e);
    tx_q.push_back(8'hA5);
    send_gap(8'h01, gaps);
    send_gap(a[15:8], gaps);
    send_gap(a[7:0], gaps);
    for (int i = ND - 1; i > 0; i--) send_gap(d[i*8 +: 8], gaps);
    send_byte(d[7:0]);
  endtask

  task automatic do_read(logic [ADDR_W-1:0] a, bit gaps);
    wb_exp_t           e;
    logic [DATA_W-1:0] v;
    v = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    e.we = 1'b0; e.adr = a; e.dat = '0;
    wb_q.push_back(e);
    for (int i = ND - 1; i >= 0; i--) tx_q.push_back(v[i*8 +: 8]);
    send_gap(8'h02, gaps);
    send_gap(a[15:8], gaps);
    send_byte(a[7:0]);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((tx_q.size() != 0 || wb_q.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    check("drain_done", 32'(tx_q.size() + wb_q.size()), 32'd0);
    tx_q.delete();
    wb_q.delete();
    repeat (2) tick();
  endtask

  task automatic count_cyc(string name, int exp_n);
    int n = 0;
    while (wb_cyc && n < 100) begin
      n++;
      tick();
    end
    check(name, 32'(n), 32'(exp_n));
  endtask

  task automatic check_reset_outputs();
    check("rst_cyc", {31'd0, wb_cyc}, 32'd0);
    check("rst_stb", {31'd0, wb_stb}, 32'd0);
    check("rst_we", {31'd0, wb_we}, 32'd0);
    check("rst_adr", 32'(wb_adr), 32'd0);
    check("rst_dat_o", wb_dat_o, 32'd0);
    check("rst_sel", 32'(wb_sel), 32'hF);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) tick();
    check_reset_outputs();
    rst = 1'b0;
    exp_ovr = 1'b0;
    tx_q.delete();
    wb_q.delete();
    tick();
  endtask

  // RAM slave: acks after a per-transfer delay of 0..3 cycles.
  initial begin
    int wait_c = 0;
    int cur_delay = 0;
    forever begin
      tick();
      if (wb_cyc && wb_stb && !wb_ack && !no_ack && !rst) begin
        if (wait_c >= cur_delay) begin
          wb_ack = 1'b1;
          if (wb_we) ram[wb_adr] = wb_dat_o;
          else wb_dat_i = ram.exists(wb_adr) ? ram[wb_adr] : init_val(wb_adr);
        end else begin
          wait_c++;
          wb_dat_i = $urandom;
        end
      end else begin
        wb_ack = 1'b0;
        wb_dat_i = $urandom;
        wait_c = 0;
        cur_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
      end
    end
  end

  // Random backpressure when enabled.
  initial begin
    forever begin
      tick();
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Wishbone monitor: compares each acknowledged transfer against the scoreboard.
  initial begin
    bit ack_prev = 1'b0;
    wb_exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        ack_prev = 1'b0;
      end else begin
        if (ack_prev) check("cyc_low_after_ack", {31'd0, wb_cyc}, 32'd0);
        ack_prev = 1'b0;
        if (wb_cyc && wb_ack) begin
          ack_prev = 1'b1;
          check("wb_stb", {31'd0, wb_stb}, 32'd1);
          check("wb_sel", 32'(wb_sel), 32'hF);
          if (wb_q.size() == 0) begin
            check("wb_unexpected", 32'd1, 32'd0);
          end else begin
            e = wb_q.pop_front();
            check("wb_we", {31'd0, wb_we}, {31'd0, e.we});
            check("wb_adr", 32'(wb_adr), 32'(e.adr));
            if (e.we) check("wb_dat_o", wb_dat_o, e.dat);
          end
        end
      end
    end
  end

  // TX monitor: byte order/content plus stability while stalled.
  initial begin
    bit         stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("tx_valid_hold", {31'd0, tx_valid}, 32'd1);
          check("tx_data_hold", 32'(tx_data), 32'(stall_data));
        end
        if (tx_valid && tx_ready) begin
          if (tx_q.size() == 0) begin
            check("tx_unexpected", 32'd1, 32'd0);
          end else begin
            b = tx_q.pop_front();
            check("tx_byte", 32'(tx_data), 32'(b));
          end
        end
        stall_prev = tx_valid && !tx_ready;
        stall_data = tx_data;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [ADDR_W-1:0] a;
    logic [7:0]        junk[4];
    junk[0] = 8'h7F; junk[1] = 8'h00; junk[2] = 8'h55; junk[3] = 8'hFF;

    tick();
    apply_reset();

    // Directed write, zero-wait ack, minimum turnaround.
    fixed_delay = 0;
    do_write(16'h0010, 32'hDEADBEEF, 1'b0);
    check("turnaround_cyc", {31'd0, wb_cyc}, 32'd1);
    count_cyc("write_cyc_len", 1);
    wait_idle();

    // Directed read with a 3-cycle ack delay.
    fixed_delay = 3;
    do_read(16'h0010, 1'b0);
    count_cyc("read_cyc_len", 4);
    wait_idle();

    // Garbage byte in IDLE, then a read under random backpressure.
    fixed_delay = -1;
    rand_ready = 1'b1;
    send_byte(8'h7F);
    tick();
    do_read(16'h0010, 1'b1);
    wait_idle();
    check("no_overrun_yet", {31'd0, overrun}, 32'd0);

    // Extra byte while the response is streaming.
    do_read(16'h0010, 1'b0);
    for (int n = 0; n < 200 && !tx_valid; n++) tick();
    check("resp_reached", {31'd0, tx_valid}, 32'd1);
    send_byte(8'h3C);
    exp_ovr = 1'b1;
    wait_idle();
    check("overrun_set", {31'd0, overrun}, {31'd0, exp_ovr});
    do_write(16'h0020, 32'h12345678, 1'b1);
    wait_idle();
    do_read(16'h0020, 1'b1);
    wait_idle();
    check("overrun_sticky", {31'd0, overrun}, {31'd0, exp_ovr});

    // Reset mid-write after the address bytes: no bus cycle must follow.
    rand_ready = 1'b0;
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h30);
    send_byte(8'hAA);
    apply_reset();
    repeat (10) tick();
    check("no_cyc_after_rst", {31'd0, wb_cyc}, 32'd0);
    do_write(16'h0030, 32'hCAFEF00D, 1'b0);
    wait_idle();
    do_read(16'h0030, 1'b0);
    wait_idle();

    // Randomized traffic against the packet-level model.
    rand_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      a = 16'h0100 + 16'($urandom_range(0, 7) * 4);
      if ($urandom_range(0, 3) == 0) begin
        send_byte(junk[$urandom_range(0, 3)]);
      end
      if ($urandom_range(0, 1) == 1) do_write(a, $urandom, 1'b1);
      else do_read(a, 1'b1);
      wait_idle();
    end
    check("overrun_final", {31'd0, overrun}, {31'd0, exp_ovr});

`ifdef UART2WB_TIMEOUT_EN
    // No ack: bus held for TIMEOUT cycles, then error byte.
    rand_ready = 1'b0;
    no_ack = 1'b1;
    tx_q.push_back(8'hEE);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h40);
    count_cyc("timeout_cyc_len", 8);
    wait_idle();
    no_ack = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
